// File: rtl/dbg_mon_pkg.sv
// Shared types and helpers for the debug event monitor.
package dbg_mon_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam int unsigned NIB_VEC_W = 64;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned HOLD_W    = 24;

    typedef enum logic [3:0] {
        PG_STICKY   = 4'h0,
        PG_LIVE     = 4'h1,
        PG_VIEW     = 4'h2,
        PG_SNAP_CNT = 4'h3,
        PG_SNAP_PC  = 4'h4,
        PG_HOLD     = 4'h5,
        PG_STATUS   = 4'h6,
        PG_CHAN     = 4'h7,
        PG_RSV8     = 4'h8,
        PG_RSV9     = 4'h9,
        PG_RSV10    = 4'hA,
        PG_RSV11    = 4'hB,
        PG_RSV12    = 4'hC,
        PG_RSV13    = 4'hD,
        PG_RSV14    = 4'hE,
        PG_RSV15    = 4'hF
    } page_e;

    // Nibble idx of a zero-extended vector; 0 when idx lies beyond the vector.
    function automatic logic [NIB_W-1:0] nib_of(input logic [NIB_VEC_W-1:0] vec,
                                                input int unsigned          idx);
        logic [NIB_W-1:0] nib;
        nib = '0;
        if (idx < (NIB_VEC_W / NIB_W)) begin
            nib = NIB_W'(vec >> (idx * NIB_W));
        end
        return nib;
    endfunction

endpackage

// File: rtl/dbg_event_monitor_if.sv
// Event/PC inputs, LED page controls and outputs of the debug monitor.
interface dbg_event_monitor_if
    import dbg_mon_pkg::*;
#(
    parameter int unsigned NUM_EVT = 8
) ();

    logic [NUM_EVT-1:0] evt_i;
    logic               pc_valid_i;
    logic [PC_W-1:0]    pc_i;
    logic [3:0]         page_sel_i;
    logic [3:0]         chan_sel_i;
    logic [2:0]         nib_sel_i;
    logic               freeze_i;
    logic               clr_i;
    logic [NIB_W-1:0]   led_o;
    logic               done_o;

    modport master (
        output evt_i, pc_valid_i, pc_i, page_sel_i, chan_sel_i, nib_sel_i, freeze_i, clr_i,
        input  led_o, done_o
    );

    modport slave (
        input  evt_i, pc_valid_i, pc_i, page_sel_i, chan_sel_i, nib_sel_i, freeze_i, clr_i,
        output led_o, done_o
    );

endinterface

// File: rtl/dbg_evt_channel.sv
// One event channel: sticky flag, wrapping counter with overflow flag, snapshot.
module dbg_evt_channel #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             clr,
    input  logic             cap,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic [CNT_W-1:0] snap
);

    logic             sticky_d, sticky_q;
    logic             ovf_d,    ovf_q;
    logic [CNT_W-1:0] cnt_d,    cnt_q;
    logic [CNT_W-1:0] snap_d,   snap_q;

    // Clear dominates a same-cycle event; the snapshot is not affected by clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        snap_d   = snap_q;
        if (cap) begin
            snap_d = cnt_q;
        end
        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else if (evt) begin
            sticky_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            snap_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            snap_q   <= snap_d;
        end
    end

    assign sticky = sticky_q;
    assign cnt    = cnt_q;
    assign ovf    = ovf_q;
    assign snap   = snap_q;

endmodule

// File: rtl/dbg_event_monitor.sv
// Debug monitor: per-channel event counters, commit-PC tracking and LED page mux.
module dbg_event_monitor
    import dbg_mon_pkg::*;
#(
    parameter int unsigned      NUM_EVT     = 8,
    parameter int unsigned      CNT_W       = 32,
    parameter int unsigned      VIEW_LSB    = 14,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'hFFFFFF,
    parameter logic [PC_W-1:0]   DONE_PC     = 32'h000006a4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dbg_event_monitor_if.slave   mon
);

    logic [NUM_EVT-1:0] sticky_vec;
    logic [NUM_EVT-1:0] ovf_vec;
    logic [CNT_W-1:0]   cnt_arr  [NUM_EVT];
    logic [CNT_W-1:0]   snap_arr [NUM_EVT];

    logic               frz_d,      frz_q;
    logic               cap_d,      cap_q;
    logic               done_d,     done_q;
    logic [PC_W-1:0]    last_pc_d,  last_pc_q;
    logic [PC_W-1:0]    snap_pc_d,  snap_pc_q;
    logic [HOLD_W-1:0]  hold_d,     hold_q;
    logic [NIB_W-1:0]   hold_nib_d, hold_nib_q;
    logic [NIB_W-1:0]   led_d,      led_q;

    logic [CNT_W-1:0]   cnt_sel;
    logic [CNT_W-1:0]   snap_sel;
    logic               sticky_sel;
    logic               ovf_sel;

    for (genvar c = 0; c < NUM_EVT; c++) begin : g_chan
        dbg_evt_channel #(.CNT_W(CNT_W)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .evt    (mon.evt_i[c]),
            .clr    (mon.clr_i),
            .cap    (cap_q),
            .sticky (sticky_vec[c]),
            .cnt    (cnt_arr[c]),
            .ovf    (ovf_vec[c]),
            .snap   (snap_arr[c])
        );
    end

    // cap_q pulses one cycle after the freeze rising edge, so the snapshot
    // picks up counters that already include events of the edge cycle.
    always_comb begin
        frz_d      = mon.freeze_i;
        cap_d      = mon.freeze_i & ~frz_q;
        done_d     = done_q;
        last_pc_d  = last_pc_q;
        snap_pc_d  = snap_pc_q;
        hold_d     = hold_q;
        hold_nib_d = hold_nib_q;
        if (mon.pc_valid_i) begin
            last_pc_d = mon.pc_i;
        end
        if (cap_q) begin
            snap_pc_d = last_pc_q;
        end
        if (mon.pc_valid_i && (mon.pc_i == DONE_PC)) begin
            done_d = 1'b1;
        end
        if ((hold_q == '0) && mon.pc_valid_i) begin
            hold_nib_d = mon.pc_i[5:2];
            hold_d     = HOLD_CYCLES;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        if (mon.clr_i) begin
            done_d = 1'b0;
            hold_d = '0;
        end
    end

    // Channel select; out-of-range selects read as zero.
    always_comb begin
        cnt_sel    = '0;
        snap_sel   = '0;
        sticky_sel = 1'b0;
        ovf_sel    = 1'b0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (mon.chan_sel_i == 4'(i)) begin
                cnt_sel    = cnt_arr[i];
                snap_sel   = snap_arr[i];
                sticky_sel = sticky_vec[i];
                ovf_sel    = ovf_vec[i];
            end
        end
    end

    always_comb begin
        led_d = '0;
        case (page_e'(mon.page_sel_i))
            PG_STICKY:   led_d = nib_of(NIB_VEC_W'(sticky_vec), 32'(mon.nib_sel_i));
            PG_LIVE:     led_d = nib_of(NIB_VEC_W'(mon.evt_i), 32'(mon.nib_sel_i));
            PG_VIEW:     led_d = cnt_sel[VIEW_LSB +: NIB_W];
            PG_SNAP_CNT: led_d = nib_of(NIB_VEC_W'(snap_sel), 32'(mon.nib_sel_i));
            PG_SNAP_PC:  led_d = nib_of(NIB_VEC_W'(snap_pc_q), 32'(mon.nib_sel_i));
            PG_HOLD:     led_d = hold_nib_q;
            PG_STATUS:   led_d = {done_q, |sticky_vec, |ovf_vec, frz_q};
            PG_CHAN:     led_d = {|mon.evt_i, mon.pc_valid_i, ovf_sel, sticky_sel};
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_q      <= 1'b0;
            cap_q      <= 1'b0;
            done_q     <= 1'b0;
            last_pc_q  <= '0;
            snap_pc_q  <= '0;
            hold_q     <= '0;
            hold_nib_q <= '0;
            led_q      <= '0;
        end else begin
            frz_q      <= frz_d;
            cap_q      <= cap_d;
            done_q     <= done_d;
            last_pc_q  <= last_pc_d;
            snap_pc_q  <= snap_pc_d;
            hold_q     <= hold_d;
            hold_nib_q <= hold_nib_d;
            led_q      <= led_d;
        end
    end

    assign mon.led_o  = led_q;
    assign mon.done_o = done_q;

endmodule

// File: tb/tb_dbg_event_monitor.sv
// Directed bench for dbg_event_monitor with CNT_W=8, VIEW_LSB=4, HOLD_CYCLES=4.
module tb_dbg_event_monitor;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dbg_event_monitor_if #(.NUM_EVT(8)) mon ();

    dbg_event_monitor #(
        .NUM_EVT     (8),
        .CNT_W       (8),
        .VIEW_LSB    (4),
        .HOLD_CYCLES (24'd4),
        .DONE_PC     (32'h000006a4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (mon)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic view(input logic [3:0] pg, input logic [3:0] ch, input logic [2:0] nb);
        mon.page_sel_i = pg;
        mon.chan_sel_i = ch;
        mon.nib_sel_i  = nb;
        step(1);
    endtask

    task automatic freeze_pulse();
        mon.freeze_i = 1'b1;
        step(1);
        mon.freeze_i = 1'b0;
        step(2);
    endtask

    initial begin
        rst_n          = 1'b0;
        mon.evt_i      = 8'h00;
        mon.pc_valid_i = 1'b0;
        mon.pc_i       = 32'h0;
        mon.page_sel_i = 4'h0;
        mon.chan_sel_i = 4'h0;
        mon.nib_sel_i  = 3'd0;
        mon.freeze_i   = 1'b0;
        mon.clr_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // Reset state on every page
        chk("rst_done", {3'b000, mon.done_o}, 4'h0);
        for (int p = 0; p < 16; p++) begin
            view(4'(p), 4'h0, 3'd0);
            chk($sformatf("rst_page%0d", p), mon.led_o, 4'h0);
        end

        // Five events on channel 3, then snapshot
        view(4'h3, 4'h3, 3'd0);
        for (int k = 0; k < 5; k++) begin
            mon.evt_i = 8'h08;
            step(1);
            mon.evt_i = 8'h00;
            step(1);
        end
        chk("snap_before_freeze", mon.led_o, 4'h0);
        freeze_pulse();
        chk("snap_cnt3_nib0", mon.led_o, 4'h5);
        view(4'h3, 4'h3, 3'd1);
        chk("snap_cnt3_nib1", mon.led_o, 4'h0);
        view(4'h3, 4'h3, 3'd2);
        chk("snap_cnt3_nib_above_w", mon.led_o, 4'h0);
        view(4'h0, 4'h0, 3'd0);
        chk("sticky_g0", mon.led_o, 4'b1000);
        view(4'h6, 4'h0, 3'd0);
        chk("status_after_count", mon.led_o, 4'b0100);
        view(4'h7, 4'h3, 3'd0);
        chk("chan3_flags", mon.led_o, 4'b0001);
        view(4'h7, 4'd11, 3'd0);
        chk("chan_out_of_range", mon.led_o, 4'b0000);

        // Live event page, groups 0 and 1
        view(4'h1, 4'h3, 3'd0);
        mon.evt_i = 8'h05;
        step(1);
        chk("live_g0", mon.led_o, 4'h5);
        mon.nib_sel_i = 3'd1;
        mon.evt_i     = 8'hA0;
        step(1);
        chk("live_g1", mon.led_o, 4'hA);
        mon.page_sel_i = 4'h7;
        step(1);
        chk("live_chan_page", mon.led_o, 4'b1001);
        mon.evt_i = 8'h00;

        // Clear, then check event-to-LED latency
        mon.clr_i = 1'b1;
        step(1);
        mon.clr_i = 1'b0;
        view(4'h0, 4'h0, 3'd0);
        chk("sticky_after_clr", mon.led_o, 4'h0);
        mon.evt_i = 8'h02;
        step(1);
        mon.evt_i = 8'h00;
        chk("evt_latency_edge1", mon.led_o, 4'h0);
        step(1);
        chk("evt_latency_edge2", mon.led_o, 4'b0010);
        view(4'h3, 4'h3, 3'd0);
        chk("snap_survives_clr", mon.led_o, 4'h5);

        // 256 events on channel 0 wrap the 8-bit counter
        mon.clr_i = 1'b1;
        step(1);
        mon.clr_i = 1'b0;
        view(4'h2, 4'h0, 3'd0);
        mon.evt_i = 8'h01;
        step(255);
        chk("view_cnt254", mon.led_o, 4'hF);
        step(1);
        mon.evt_i = 8'h00;
        chk("view_cnt255", mon.led_o, 4'hF);
        step(1);
        chk("view_after_wrap", mon.led_o, 4'h0);
        view(4'h7, 4'h0, 3'd0);
        chk("wrap_ovf_chan0", mon.led_o, 4'b0011);
        view(4'h6, 4'h0, 3'd0);
        chk("wrap_status", mon.led_o, 4'b0110);

        // Clear and event in the same cycle: clear wins
        view(4'h7, 4'h0, 3'd0);
        mon.clr_i = 1'b1;
        mon.evt_i = 8'h01;
        step(1);
        mon.clr_i = 1'b0;
        mon.evt_i = 8'h00;
        step(1);
        chk("collision_chan0", mon.led_o, 4'b0000);
        view(4'h3, 4'h0, 3'd0);
        freeze_pulse();
        chk("collision_cnt0", mon.led_o, 4'h0);

        // DONE_PC commit and PC snapshot
        view(4'h6, 4'h0, 3'd0);
        mon.pc_valid_i = 1'b1;
        mon.pc_i       = 32'h000006a4;
        step(1);
        mon.pc_valid_i = 1'b0;
        mon.pc_i       = 32'h0;
        step(1);
        chk("done_set", {3'b000, mon.done_o}, 4'h1);
        chk("status_done", mon.led_o, 4'b1000);
        view(4'h4, 4'h0, 3'd2);
        freeze_pulse();
        chk("snap_pc_nib2", mon.led_o, 4'h6);
        view(4'h4, 4'h0, 3'd1);
        chk("snap_pc_nib1", mon.led_o, 4'hA);
        view(4'h4, 4'h0, 3'd0);
        chk("snap_pc_nib0", mon.led_o, 4'h4);
        view(4'h5, 4'h0, 3'd0);
        chk("hold_from_done_pc", mon.led_o, 4'h9);
        mon.clr_i = 1'b1;
        step(1);
        mon.clr_i = 1'b0;
        chk("done_cleared", {3'b000, mon.done_o}, 4'h0);

        // Hold: back-to-back commits, one capture per HOLD_CYCLES+1 cycles
        view(4'h5, 4'h0, 3'd0);
        mon.pc_valid_i = 1'b1;
        mon.pc_i       = 32'h4;
        step(1);
        mon.pc_i = 32'h8;
        step(1);
        mon.pc_i = 32'hC;
        step(1);
        chk("hold_first", mon.led_o, 4'h1);
        step(3);
        chk("hold_kept", mon.led_o, 4'h1);
        step(1);
        chk("hold_recapture", mon.led_o, 4'h3);
        mon.pc_valid_i = 1'b0;
        mon.pc_i       = 32'h0;

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", mon.led_o, 4'h0);
        rst_n = 1'b1;
        step(1);
        view(4'h4, 4'h0, 3'd2);
        chk("async_rst_snap_pc", mon.led_o, 4'h0);
        view(4'h5, 4'h0, 3'd0);
        chk("async_rst_hold_nib", mon.led_o, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
